fmap_window_scheduler: RTL and testbench

Sequencer for the 3x3 feature-map buffer: it generates the nine (column, row) read addresses for every 3x3 window of a programmed image region, raster order, and tracks the buffer's one-cycle registered read latency. It produces a valid/ready stream of window-aligned fmap data toward the MAC array. It sits between the layer controller, which issues start and image size, and the buffer's read-address inputs `readi_w`/`readi_h`.

---
 rtl/fmap_window_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_fmap_window_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_window_scheduler.sv
// -----------------------------------------------------------------------------
// fmap_window_scheduler
//
// Purpose:
//   Walks every 3x3 window of a programmed image region in raster order. For
//   each window it drives the nine (column, row) tap read addresses of the
//   feature-map buffer. It follows the buffer's one-cycle registered read
//   latency, so a valid/ready stream of window-aligned fmap data reaches the
//   MAC array.
//
// Optional feature:
//   STRIDE2_EN - when defined, adds the stride2 input. stride2 is latched with
//                start and selects a window step of 2 instead of 1.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        one-cycle scan request, sampled only while idle
//   stride2      (STRIDE2_EN only) step 2 when 1, else step 1
//   img_w        image width in columns, legal 3..width
//   img_h        image height in rows, legal 3..height
//   readi_w      nine tap column addresses, tap 0 in the MSBs
//   readi_h      nine tap row addresses, tap 0 in the MSBs
//   fmap_valid   buffer output holds the window at win_x/win_y
//   fmap_ready   downstream accepts the current window
//   win_x/win_y  top-left corner of the window currently on fmap
//   busy         scan in progress
//   done         one-cycle pulse at the end of a scan or after an illegal size
//   err          sticky illegal-size flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module fmap_window_scheduler #(
    parameter int width    = 57,
    parameter int height   = 8,
    parameter int width_b  = 6,
    parameter int height_b = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
`ifdef STRIDE2_EN
    input  logic                  stride2,
`endif
    input  logic [width_b-1:0]    img_w,
    input  logic [height_b:0]     img_h,
    output logic [width_b*9-1:0]  readi_w,
    output logic [height_b*9-1:0] readi_h,
    output logic                  fmap_valid,
    input  logic                  fmap_ready,
    output logic [width_b-1:0]    win_x,
    output logic [height_b-1:0]   win_y,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int XW = width_b + 2;
    localparam int YW = height_b + 2;
    localparam logic [31:0] WIDTH_U  = width;
    localparam logic [31:0] HEIGHT_U = height;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nx;

    // issue registers: the window whose addresses are presented next
    logic [width_b-1:0]  x_a;
    logic [height_b-1:0] y_a;
    logic                addr_vld;

    logic [width_b-1:0]  w_l;
    logic [height_b:0]   h_l;
    logic                bad_pend;

    logic                size_ok;
    logic                load;
    logic                flag_bad;
    logic                finish;
    logic                stall;
    logic                xfer;
    logic                accept;
    logic                last_x;
    logic                last_y;
    logic                rd_en;
    logic [1:0]          step;
    logic [XW-1:0]       nx_x;
    logic [XW-1:0]       lim_x;
    logic [YW-1:0]       nx_y;
    logic [YW-1:0]       lim_y;
    logic [width_b-1:0]  rx;
    logic [height_b-1:0] ry;

`ifdef STRIDE2_EN
    logic stride_l;
    assign step = stride_l ? 2'd2 : 2'd1;
`else
    assign step = 2'd1;
`endif

    assign size_ok = (32'(img_w) >= 32'd3) && (32'(img_w) <= WIDTH_U) &&
                     (32'(img_h) >= 32'd3) && (32'(img_h) <= HEIGHT_U);

    assign stall  = fmap_valid && !fmap_ready;
    assign xfer   = addr_vld && !stall;
    assign accept = fmap_valid && fmap_ready;

    assign nx_x   = XW'(x_a) + XW'(step);
    assign lim_x  = XW'(w_l) - XW'(3);
    assign nx_y   = YW'(y_a) + YW'(step);
    assign lim_y  = YW'(h_l) - YW'(3);
    assign last_x = nx_x > lim_x;
    assign last_y = nx_y > lim_y;

    assign busy = (state != IDLE);

    // While the window on fmap is stalled, the buffer keeps re-reading that
    // window's taps so its registered output stays stable. Otherwise the taps
    // of the next window to issue are presented. With nothing in flight, the
    // address bus is parked at zero.
    assign rx    = stall ? win_x : x_a;
    assign ry    = stall ? win_y : y_a;
    assign rd_en = addr_vld || fmap_valid;

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign readi_w[(8-(3*r+c))*width_b +: width_b] =
                rd_en ? (rx + width_b'(c)) : '0;
            assign readi_h[(8-(3*r+c))*height_b +: height_b] =
                rd_en ? (ry + height_b'(r)) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        flag_bad = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                // an illegal request still completing its done pulse blocks a new start
                if (start && !bad_pend) begin
                    if (size_ok) begin
                        load     = 1'b1;
                        state_nx = RUN;
                    end else begin
                        flag_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer && last_x && last_y) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_a        <= '0;
            y_a        <= '0;
            addr_vld   <= 1'b0;
            w_l        <= '0;
            h_l        <= '0;
            bad_pend   <= 1'b0;
            fmap_valid <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef STRIDE2_EN
            stride_l   <= 1'b0;
`endif
        end else begin
            done     <= finish || bad_pend;
            bad_pend <= flag_bad;

            if (bad_pend) begin
                err <= 1'b1;
            end else if (load) begin
                err <= 1'b0;
            end

            if (load) begin
                w_l      <= img_w;
                h_l      <= img_h;
                x_a      <= '0;
                y_a      <= '0;
                addr_vld <= 1'b1;
`ifdef STRIDE2_EN
                stride_l <= stride2;
`endif
            end else if (xfer) begin
                if (last_x) begin
                    x_a <= '0;
                    if (last_y) begin
                        addr_vld <= 1'b0;
                    end else begin
                        y_a <= nx_y[height_b-1:0];
                    end
                end else begin
                    x_a <= nx_x[width_b-1:0];
                end
            end

            // the buffer captures the presented taps this edge; follow with
            // the matching window coordinates one cycle later
            if (xfer) begin
                fmap_valid <= 1'b1;
                win_x      <= x_a;
                win_y      <= y_a;
            end else if (accept) begin
                fmap_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmap_window_scheduler.sv
module tb_fmap_window_scheduler;

    localparam int WB = 6;
    localparam int HB = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [WB-1:0]     img_w = '0;
    logic [HB:0]       img_h = '0;
    logic [WB*9-1:0]   readi_w;
    logic [HB*9-1:0]   readi_h;
    logic              fmap_valid;
    logic              fmap_ready = 1'b1;
    logic [WB-1:0]     win_x;
    logic [HB-1:0]     win_y;
    logic              busy;
    logic              done;
    logic              err;
`ifdef STRIDE2_EN
    logic              stride2 = 1'b0;
`endif

    fmap_window_scheduler #(
        .width(57), .height(8), .width_b(WB), .height_b(HB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
`ifdef STRIDE2_EN
        .stride2(stride2),
`endif
        .img_w(img_w),
        .img_h(img_h),
        .readi_w(readi_w),
        .readi_h(readi_h),
        .fmap_valid(fmap_valid),
        .fmap_ready(fmap_ready),
        .win_x(win_x),
        .win_y(win_y),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected windows of the current scan, raster order
    int exp_x[$];
    int exp_y[$];
    int log_x[$];
    int log_y[$];
    int acc_cnt = 0;
    int stall_x = -1;
    int stall_y = -1;
    int stall_left = 0;
    int held_cnt = 0;
    time t0 = 0;
    bit prev_stall = 0;
    logic [WB-1:0] px;
    logic [HB-1:0] py;
    bit seen_first = 0;
    logic [WB*9-1:0] first_w, last_w, buf_w;
    logic [HB*9-1:0] first_h, last_h, buf_h;

    function automatic logic [WB*9-1:0] taps_w(input int x);
        logic [WB*9-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[(8-k)*WB +: WB] = WB'(x + k % 3);
        return v;
    endfunction

    function automatic logic [HB*9-1:0] taps_h(input int y);
        logic [HB*9-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[(8-k)*HB +: HB] = HB'(y + k / 3);
        return v;
    endfunction

    // the feature-map buffer: registered read of the tap addresses
    always @(posedge clk) begin
        buf_w <= readi_w;
        buf_h <= readi_h;
    end

    // downstream: back-pressure on the selected window
    always @(posedge clk) begin
        #1;
        if (fmap_valid && win_x == stall_x && win_y == stall_y && stall_left > 0) begin
            fmap_ready = 1'b0;
            stall_left--;
        end else begin
            fmap_ready = 1'b1;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (fmap_valid) begin
                chk("fmap_taps_w", 64'(buf_w), 64'(taps_w(int'(win_x))));
                chk("fmap_taps_h", 64'(buf_h), 64'(taps_h(int'(win_y))));
                if (!seen_first) begin
                    first_w = buf_w;
                    first_h = buf_h;
                    seen_first = 1;
                end
                if (prev_stall) begin
                    chk("hold_x", 64'(win_x), 64'(px));
                    chk("hold_y", 64'(win_y), 64'(py));
                end
                if (win_x == stall_x && win_y == stall_y) held_cnt++;
                if (fmap_ready) begin
                    if (exp_x.size() == 0) begin
                        chk("unexpected_window", 64'(1), 64'(0));
                    end else begin
                        chk("win_x", 64'(win_x), 64'(exp_x.pop_front()));
                        chk("win_y", 64'(win_y), 64'(exp_y.pop_front()));
                    end
                    log_x.push_back(int'(win_x));
                    log_y.push_back(int'(win_y));
                    last_w = buf_w;
                    last_h = buf_h;
                    acc_cnt++;
                end
            end
            prev_stall = fmap_valid && !fmap_ready;
            px = win_x;
            py = win_y;
        end
    end

    task automatic build_model(input int w, input int h, input int s);
        exp_x.delete();
        exp_y.delete();
        log_x.delete();
        log_y.delete();
        acc_cnt = 0;
        seen_first = 0;
        for (int y = 0; y <= h - 3; y += s)
            for (int x = 0; x <= w - 3; x += s) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endtask

    task automatic do_start(input int w, input int h, input int s);
        @(negedge clk);
        img_w = WB'(w);
        img_h = (HB+1)'(h);
`ifdef STRIDE2_EN
        stride2 = (s == 2);
`endif
        start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int w, input int h, input int s,
                            input int sx, input int sy, input int slen,
                            input int exp_n, input int exp_cyc);
        int cyc;
        build_model(w, h, s);
        stall_x = sx;
        stall_y = sy;
        stall_left = slen;
        held_cnt = 0;
        do_start(w, h, s);
        chk({tag, "_err_clear"}, 64'(err), 64'(0));
        cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = int'(($time - t0 - 5) / 10);
                break;
            end
        end
        chk({tag, "_scan_cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        chk({tag, "_accepted"}, 64'(acc_cnt), 64'(exp_n));
        chk({tag, "_model_left"}, 64'(exp_x.size()), 64'(0));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        stall_x = -1;
        stall_y = -1;
    endtask

    initial begin
        int lx[6] = '{0, 1, 2, 0, 1, 2};
        int ly[6] = '{0, 0, 0, 1, 1, 1};
        bit bad_seen;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_fmap_valid", 64'(fmap_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_readi_w", 64'(readi_w), 64'(0));
        chk("rst_readi_h", 64'(readi_h), 64'(0));
        reset_n = 1'b1;

        // 5x4, ready held high
        run_scan("s5x4", 5, 4, 1, -1, -1, 0, 6, 7);
        for (int i = 0; i < 6; i++) begin
            chk("order_x", 64'((i < log_x.size()) ? log_x[i] : -1), 64'(lx[i]));
            chk("order_y", 64'((i < log_y.size()) ? log_y[i] : -1), 64'(ly[i]));
        end
        chk("first_tap8_col", 64'(first_w[WB-1:0]), 64'(2));
        chk("first_tap8_row", 64'(first_h[HB-1:0]), 64'(2));

        // same size, window (2,0) held by 3 stall cycles
        run_scan("stall", 5, 4, 1, 2, 0, 3, 6, 10);
        chk("stall_held_cycles", 64'(held_cnt), 64'(4));

        // illegal width
        @(negedge clk);
        img_w = WB'(2);
        img_h = (HB+1)'(4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("bad_err_e0", 64'(err), 64'(0));
        chk("bad_done_e0", 64'(done), 64'(0));
        @(negedge clk);
        chk("bad_err_e1", 64'(err), 64'(1));
        chk("bad_done_e1", 64'(done), 64'(1));
        bad_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fmap_valid || busy || done) bad_seen = 1;
        end
        chk("bad_no_activity", 64'(bad_seen), 64'(0));
        chk("bad_err_sticky", 64'(err), 64'(1));

        // legal start clears err
        run_scan("after_bad", 5, 4, 1, -1, -1, 0, 6, 7);
        chk("err_after_legal", 64'(err), 64'(0));

        // minimum size
        run_scan("s3x3", 3, 3, 1, -1, -1, 0, 1, 2);

        // maximum size
        run_scan("s57x8", 57, 8, 1, -1, -1, 0, 330, 331);
        chk("max_last_x", 64'(log_x.size() > 0 ? log_x[log_x.size()-1] : -1), 64'(54));
        chk("max_last_y", 64'(log_y.size() > 0 ? log_y[log_y.size()-1] : -1), 64'(5));
        chk("max_last_tap8_col", 64'(last_w[WB-1:0]), 64'(56));
        chk("max_last_tap8_row", 64'(last_h[HB-1:0]), 64'(7));

        // illegal height
        @(negedge clk);
        img_w = WB'(5);
        img_h = (HB+1)'(9);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("badh_err", 64'(err), 64'(1));
        chk("badh_busy", 64'(busy), 64'(0));

        // reset mid-scan
        build_model(57, 8, 1);
        do_start(57, 8, 1);
        for (int i = 0; i < 100 && acc_cnt < 10; i++) begin
            @(negedge clk);
            #1;
        end
        chk("midrst_reached10", 64'(acc_cnt >= 10), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_fmap_valid", 64'(fmap_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        chk("midrst_win", 64'({win_x, win_y}), 64'(0));
        chk("midrst_readi", 64'({readi_w, readi_h}), 64'(0));
        exp_x.delete();
        exp_y.delete();
        @(negedge clk);
        chk("midrst_done", 64'(done), 64'(0));
        #2 reset_n = 1'b1;
        run_scan("restart", 5, 4, 1, -1, -1, 0, 6, 7);
        chk("restart_first_x", 64'(log_x.size() > 0 ? log_x[0] : -1), 64'(0));
        chk("restart_first_y", 64'(log_y.size() > 0 ? log_y[0] : -1), 64'(0));

`ifdef STRIDE2_EN
        begin
            int sv[3] = '{0, 2, 4};
            run_scan("stride2", 7, 7, 2, -1, -1, 0, 9, 10);
            for (int i = 0; i < 9; i++) begin
                chk("s2_x", 64'((i < log_x.size()) ? log_x[i] : -1), 64'(sv[i % 3]));
                chk("s2_y", 64'((i < log_y.size()) ? log_y[i] : -1), 64'(sv[i / 3]));
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
